// File: rtl/ase_pkg.sv
// rtl/ase_pkg.sv - CCI-P TX header layout, request types and scheduler state encoding
package ase_pkg;

  localparam int CCIP_TX_HDR_WIDTH = 74;
  localparam int REQTYPE_LSB       = 64;

  localparam logic [3:0] CCIP_WRLINE_I = 4'h1;
  localparam logic [3:0] CCIP_WRFENCE  = 4'h4;

  typedef struct packed {
    logic [1:0]  vc_sel;
    logic [1:0]  rsvd1;
    logic [1:0]  cl_len;
    logic [3:0]  req_type;
    logic [5:0]  rsvd0;
    logic [41:0] address;
    logic [15:0] mdata;
  } TxHdr_t;

  typedef enum logic {
    SCH_ARB,
    SCH_DRAIN
  } sched_state_t;

endpackage

// File: rtl/ase_rr_pick.sv
// rtl/ase_rr_pick.sv - rotate-priority finder: first valid index after ptr, wrapping
module ase_rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic          found,
  output logic [IW-1:0] idx
);

  always_comb begin
    logic [IW-1:0] c;
    found = 1'b0;
    idx   = ptr;
    c     = '0;
    // k runs to N so that ptr itself is the lowest-priority candidate
    for (int k = 1; k <= N; k++) begin
      c = IW'((32'(ptr) + k) % N);
      if (!found && valid[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end

endmodule

// File: rtl/ase_tx_tid_scheduler.sv
// rtl/ase_tx_tid_scheduler.sv - round-robin CCI-P TX scheduler with TID tagging,
// outstanding limit and write-fence draining
module ase_tx_tid_scheduler
  import ase_pkg::*;
#(
  parameter int NUM_REQ         = 4,
  parameter int TID_WIDTH       = 32,
  parameter int MAX_OUTSTANDING = 64,
  parameter int HDR_WIDTH       = CCIP_TX_HDR_WIDTH,
  localparam int SRC_W          = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
  localparam int CNT_W          = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*HDR_WIDTH-1:0] req_hdr,
  output logic [NUM_REQ-1:0]           req_grant,
  input  logic                         tx_almfull,
  output logic                         out_valid,
  output logic [HDR_WIDTH-1:0]         out_hdr,
  output logic [TID_WIDTH-1:0]         out_tid,
  output logic [SRC_W-1:0]             out_src,
  input  logic                         rsp_valid,
  output logic [CNT_W-1:0]             outstanding,
  output logic                         err_underflow
);

  sched_state_t           state_q, state_d;
  logic [SRC_W-1:0]       ptr_q, ptr_d, latch_q, latch_d, out_src_q, out_src_d;
  logic [TID_WIDTH-1:0]   tid_q, tid_d, out_tid_q, out_tid_d;
  logic [HDR_WIDTH-1:0]   out_hdr_q, out_hdr_d, sel_hdr;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   out_valid_q, out_valid_d, err_q, err_d;
  logic                   cand_found, sel_fence, room, do_grant, inc;
  logic [SRC_W-1:0]       cand_idx, sel_idx;

  ase_rr_pick #(.N(NUM_REQ), .IW(SRC_W)) u_pick (
    .valid (req_valid),
    .ptr   (ptr_q),
    .found (cand_found),
    .idx   (cand_idx)
  );

  // While draining, only the latched fence owner is considered
  assign sel_idx   = (state_q == SCH_DRAIN) ? latch_q : cand_idx;
  assign sel_hdr   = req_hdr[int'(sel_idx) * HDR_WIDTH +: HDR_WIDTH];
  assign sel_fence = (sel_hdr[REQTYPE_LSB +: 4] == CCIP_WRFENCE);
  assign room      = (cnt_q < CNT_W'(MAX_OUTSTANDING)) || rsp_valid;
  assign req_grant = do_grant ? (NUM_REQ'(1) << sel_idx) : '0;

  always_comb begin
    state_d  = state_q;
    latch_d  = latch_q;
    ptr_d    = ptr_q;
    do_grant = 1'b0;
    case (state_q)
      SCH_ARB: begin
        if (cand_found) begin
          if (sel_fence && (cnt_q != '0)) begin
            state_d = SCH_DRAIN;
            latch_d = cand_idx;
          end else if (!tx_almfull && (sel_fence || room)) begin
            do_grant = 1'b1;
          end
        end
      end
      SCH_DRAIN: begin
        if (!req_valid[latch_q]) begin
          state_d = SCH_ARB;
        end else if ((cnt_q == '0) && !tx_almfull) begin
          do_grant = 1'b1;
          state_d  = SCH_ARB;
        end
      end
      default: state_d = SCH_ARB;
    endcase
    if (do_grant) ptr_d = sel_idx;
  end

  always_comb begin
    out_valid_d = do_grant;
    out_hdr_d   = out_hdr_q;
    out_tid_d   = out_tid_q;
    out_src_d   = out_src_q;
    tid_d       = tid_q;
    if (do_grant) begin
      out_hdr_d = sel_hdr;
      out_tid_d = tid_q;
      out_src_d = sel_idx;
      tid_d     = tid_q + TID_WIDTH'(1);
    end
    // Fences never occupy a slot; a retire at zero is flagged and ignored
    inc   = do_grant && !sel_fence;
    cnt_d = cnt_q;
    err_d = err_q;
    if (rsp_valid && (cnt_q == '0)) err_d = 1'b1;
    if (inc && !rsp_valid) begin
      cnt_d = cnt_q + CNT_W'(1);
    end else if (!inc && rsp_valid && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SCH_ARB;
      ptr_q       <= SRC_W'(NUM_REQ - 1);
      latch_q     <= '0;
      tid_q       <= '0;
      cnt_q       <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_hdr_q   <= '0;
      out_tid_q   <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      latch_q     <= latch_d;
      tid_q       <= tid_d;
      cnt_q       <= cnt_d;
      err_q       <= err_d;
      out_valid_q <= out_valid_d;
      out_hdr_q   <= out_hdr_d;
      out_tid_q   <= out_tid_d;
      out_src_q   <= out_src_d;
      if (state_q == SCH_DRAIN) assert (req_valid[latch_q]);
    end
  end

  assign out_valid     = out_valid_q;
  assign out_hdr       = out_hdr_q;
  assign out_tid       = out_tid_q;
  assign out_src       = out_src_q;
  assign outstanding   = cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_ase_tx_tid_scheduler.sv
// tb/tb_ase_tx_tid_scheduler.sv - scoreboard bench for ase_tx_tid_scheduler
module tb_ase_tx_tid_scheduler;
  import ase_pkg::*;

  localparam int HW = CCIP_TX_HDR_WIDTH;

  typedef struct packed {
    logic [1:0]    src;
    logic [31:0]   tid;
    logic [HW-1:0] hdr;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [3:0]    a_req_valid = '0, a_req_grant;
  logic [4*HW-1:0] a_req_hdr = '0;
  logic          a_almfull = 1'b0, a_rsp = 1'b0, a_out_valid, a_err;
  logic [HW-1:0] a_out_hdr;
  logic [31:0]   a_out_tid;
  logic [1:0]    a_out_src;
  logic [6:0]    a_outstanding;

  logic [3:0]    b_req_valid = '0, b_req_grant;
  logic [4*HW-1:0] b_req_hdr = '0;
  logic          b_almfull = 1'b0, b_rsp = 1'b0, b_out_valid, b_err;
  logic [HW-1:0] b_out_hdr;
  logic [1:0]    b_out_tid;
  logic [1:0]    b_out_src;
  logic [2:0]    b_outstanding;

  ase_tx_tid_scheduler dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(a_req_valid), .req_hdr(a_req_hdr),
    .req_grant(a_req_grant), .tx_almfull(a_almfull), .out_valid(a_out_valid),
    .out_hdr(a_out_hdr), .out_tid(a_out_tid), .out_src(a_out_src),
    .rsp_valid(a_rsp), .outstanding(a_outstanding), .err_underflow(a_err)
  );

  ase_tx_tid_scheduler #(.TID_WIDTH(2), .MAX_OUTSTANDING(4)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(b_req_valid), .req_hdr(b_req_hdr),
    .req_grant(b_req_grant), .tx_almfull(b_almfull), .out_valid(b_out_valid),
    .out_hdr(b_out_hdr), .out_tid(b_out_tid), .out_src(b_out_src),
    .rsp_valid(b_rsp), .outstanding(b_outstanding), .err_underflow(b_err)
  );

  exp_t a_q[$], b_q[$];
  exp_t a_e, b_e;
  logic [31:0] a_tid = '0, b_tid = '0;
  int checks = 0;
  int failures = 0;

  function automatic logic [HW-1:0] mk_hdr(input int s, input logic fence, input logic [7:0] n);
    TxHdr_t h;
    h = '0;
    h.req_type = fence ? CCIP_WRFENCE : CCIP_WRLINE_I;
    h.address  = {34'h0, n};
    h.mdata    = {6'h0, 2'(s), n};
    return h;
  endfunction

  task automatic push_a(input int s);
    exp_t e;
    e.src = 2'(s);
    e.tid = a_tid;
    e.hdr = a_req_hdr[s*HW +: HW];
    a_q.push_back(e);
    a_tid = a_tid + 1;
  endtask

  task automatic push_b(input int s);
    exp_t e;
    e.src = 2'(s);
    e.tid = b_tid;
    e.hdr = b_req_hdr[s*HW +: HW];
    b_q.push_back(e);
    b_tid = (b_tid + 1) & 32'h3;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    a_req_valid = '0; a_rsp = 1'b0; a_almfull = 1'b0;
    b_req_valid = '0; b_rsp = 1'b0; b_almfull = 1'b0;
    a_q.delete(); b_q.delete();
    a_tid = '0; b_tid = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // Issue scoreboard: every out_valid must match the oldest expected grant
  always @(negedge clk) begin
    if (rst_n && a_out_valid) begin
      checks++;
      if (a_q.size() == 0) begin
        failures++;
        $display("FAIL a_issue_unexpected got src=%0d tid=%0h required no issue", a_out_src, a_out_tid);
      end else begin
        a_e = a_q.pop_front();
        if ({a_out_src, a_out_tid, a_out_hdr} !== {a_e.src, a_e.tid, a_e.hdr}) begin
          failures++;
          $display("FAIL a_issue got src=%0d tid=%0h hdr=%0h required src=%0d tid=%0h hdr=%0h",
                   a_out_src, a_out_tid, a_out_hdr, a_e.src, a_e.tid, a_e.hdr);
        end
      end
    end
    if (rst_n && b_out_valid) begin
      checks++;
      if (b_q.size() == 0) begin
        failures++;
        $display("FAIL b_issue_unexpected got src=%0d tid=%0h required no issue", b_out_src, b_out_tid);
      end else begin
        b_e = b_q.pop_front();
        if ({b_out_src, b_out_tid, b_out_hdr} !== {b_e.src, b_e.tid[1:0], b_e.hdr}) begin
          failures++;
          $display("FAIL b_issue got src=%0d tid=%0h hdr=%0h required src=%0d tid=%0h hdr=%0h",
                   b_out_src, b_out_tid, b_out_hdr, b_e.src, b_e.tid[1:0], b_e.hdr);
        end
      end
    end
  end

  task automatic test_reset();
    #12;
    checks++;
    if ({a_out_valid, a_out_hdr, a_out_tid, a_out_src, a_outstanding, a_err, a_req_grant} !== '0) begin
      failures++;
      $display("FAIL reset_a got valid=%b tid=%0h src=%0d outst=%0d err=%b required all 0",
               a_out_valid, a_out_tid, a_out_src, a_outstanding, a_err);
    end
    checks++;
    if ({b_out_valid, b_out_hdr, b_out_tid, b_out_src, b_outstanding, b_err, b_req_grant} !== '0) begin
      failures++;
      $display("FAIL reset_b got valid=%b tid=%0h src=%0d outst=%0d err=%b required all 0",
               b_out_valid, b_out_tid, b_out_src, b_outstanding, b_err);
    end
    @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [3:0] e;
    @(posedge clk); #1;
    for (int s = 0; s < 4; s++) a_req_hdr[s*HW +: HW] = mk_hdr(s, 1'b0, 8'(8'h10 + s));
    a_req_valid = 4'hF;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e = 4'(1 << (i % 4));
      checks++;
      if (a_req_grant !== e) begin
        failures++;
        $display("FAIL rr_grant cycle=%0d got=%b required=%b", i, a_req_grant, e);
      end
      push_a(i % 4);
      @(posedge clk); #1;
    end
    a_req_valid = '0;
    @(negedge clk);
    checks++;
    if (a_outstanding !== 7'd8) begin
      failures++;
      $display("FAIL rr_outstanding got=%0d required=8", a_outstanding);
    end
    @(posedge clk); #1 a_rsp = 1'b1;
    repeat (8) @(posedge clk);
    #1 a_rsp = 1'b0;
    @(negedge clk);
    checks++;
    if (a_outstanding !== 7'd0 || a_err !== 1'b0) begin
      failures++;
      $display("FAIL rr_drain got outst=%0d err=%b required outst=0 err=0", a_outstanding, a_err);
    end
  endtask

  task automatic test_almfull();
    @(posedge clk); #1;
    a_almfull = 1'b1;
    a_req_valid = 4'hF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (a_req_grant !== 4'b0 || a_out_valid !== 1'b0) begin
        failures++;
        $display("FAIL almfull_block cycle=%0d got grant=%b out_valid=%b required 0000/0", i, a_req_grant, a_out_valid);
      end
      @(posedge clk); #1;
    end
    a_almfull = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_grant !== 4'b0001) begin
      failures++;
      $display("FAIL almfull_release got=%b required=0001", a_req_grant);
    end
    push_a(0);
    @(posedge clk); #1;
    a_req_valid = '0;
    a_rsp = 1'b1;
    @(posedge clk); #1 a_rsp = 1'b0;
  endtask

  task automatic test_limit();
    @(posedge clk); #1;
    b_req_hdr[0 +: HW] = mk_hdr(0, 1'b0, 8'h20);
    b_req_valid = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (b_req_grant !== 4'b0001) begin
        failures++;
        $display("FAIL limit_fill cycle=%0d got=%b required=0001", i, b_req_grant);
      end
      push_b(0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (b_req_grant !== 4'b0000 || b_outstanding !== 3'd4) begin
        failures++;
        $display("FAIL limit_hold cycle=%0d got grant=%b outst=%0d required 0000/4", i, b_req_grant, b_outstanding);
      end
      @(posedge clk); #1;
    end
    b_rsp = 1'b1;
    @(negedge clk);
    checks++;
    if (b_req_grant !== 4'b0001) begin
      failures++;
      $display("FAIL limit_rsp_grant got=%b required=0001", b_req_grant);
    end
    push_b(0);
    @(posedge clk); #1 b_rsp = 1'b0;
    @(negedge clk);
    checks++;
    if (b_req_grant !== 4'b0000 || b_outstanding !== 3'd4) begin
      failures++;
      $display("FAIL limit_after_rsp got grant=%b outst=%0d required 0000/4", b_req_grant, b_outstanding);
    end
    @(posedge clk); #1;
    b_req_valid = '0;
    b_rsp = 1'b1;
    repeat (4) @(posedge clk);
    #1 b_rsp = 1'b0;
  endtask

  task automatic test_tid_wrap();
    @(posedge clk); #1;
    b_req_hdr[HW +: HW] = mk_hdr(1, 1'b0, 8'h30);
    b_req_valid = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (b_req_grant !== 4'b0010) begin
        failures++;
        $display("FAIL tid_wrap_grant cycle=%0d got=%b required=0010", i, b_req_grant);
      end
      push_b(1);
      @(posedge clk); #1;
    end
    b_req_valid = '0;
    b_rsp = 1'b1;
    repeat (4) @(posedge clk);
    #1 b_rsp = 1'b0;
    @(negedge clk);
    checks++;
    if (b_outstanding !== 3'd0 || b_err !== 1'b0) begin
      failures++;
      $display("FAIL tid_wrap_drain got outst=%0d err=%b required 0/0", b_outstanding, b_err);
    end
  endtask

  task automatic test_fence_drain();
    do_reset();
    a_req_hdr[0 +: HW]  = mk_hdr(0, 1'b0, 8'h40);
    a_req_valid = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (a_req_grant !== 4'b0001) begin
        failures++;
        $display("FAIL fence_prefill cycle=%0d got=%b required=0001", i, a_req_grant);
      end
      push_a(0);
      @(posedge clk); #1;
    end
    a_req_hdr[HW +: HW]   = mk_hdr(1, 1'b1, 8'h41);
    a_req_hdr[2*HW +: HW] = mk_hdr(2, 1'b0, 8'h42);
    a_req_valid = 4'b0110;
    @(negedge clk);
    checks++;
    if (a_req_grant !== 4'b0000 || a_outstanding !== 7'd3) begin
      failures++;
      $display("FAIL fence_enter_drain got grant=%b outst=%0d required 0000/3", a_req_grant, a_outstanding);
    end
    @(posedge clk); #1 a_rsp = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (a_req_grant !== 4'b0000 || a_outstanding !== 7'(3 - k)) begin
        failures++;
        $display("FAIL fence_draining step=%0d got grant=%b outst=%0d required 0000/%0d", k, a_req_grant, a_outstanding, 3 - k);
      end
      @(posedge clk); #1;
    end
    a_rsp = 1'b0;
    @(negedge clk);
    checks++;
    if (a_req_grant !== 4'b0010) begin
      failures++;
      $display("FAIL fence_grant got=%b required=0010", a_req_grant);
    end
    push_a(1);
    @(posedge clk); #1 a_req_valid = 4'b0100;
    @(negedge clk);
    checks++;
    if (a_req_grant !== 4'b0100 || a_outstanding !== 7'd0) begin
      failures++;
      $display("FAIL fence_followup got grant=%b outst=%0d required 0100/0", a_req_grant, a_outstanding);
    end
    push_a(2);
    @(posedge clk); #1;
    a_req_valid = '0;
    a_rsp = 1'b1;
    @(negedge clk);
    checks++;
    if (a_outstanding !== 7'd1) begin
      failures++;
      $display("FAIL fence_followup_count got=%0d required=1", a_outstanding);
    end
    @(posedge clk); #1;
    a_rsp = 1'b0;
    a_req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (a_req_grant !== 4'b0010) begin
      failures++;
      $display("FAIL fence_immediate got=%b required=0010", a_req_grant);
    end
    push_a(1);
    @(posedge clk); #1 a_req_valid = '0;
  endtask

  task automatic test_underflow_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (a_err !== 1'b0) begin
      failures++;
      $display("FAIL underflow_pre got=%b required=0", a_err);
    end
    @(posedge clk); #1 a_rsp = 1'b1;
    @(posedge clk); #1 a_rsp = 1'b0;
    @(negedge clk);
    checks++;
    if (a_err !== 1'b1 || a_outstanding !== 7'd0) begin
      failures++;
      $display("FAIL underflow_set got err=%b outst=%0d required 1/0", a_err, a_outstanding);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if (a_err !== 1'b1) begin
      failures++;
      $display("FAIL underflow_sticky got=%b required=1", a_err);
    end
    @(posedge clk); #1;
    a_req_hdr[0 +: HW] = mk_hdr(0, 1'b0, 8'h55);
    a_req_valid = 4'b0001;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checks++;
      if (a_req_grant !== 4'b0001) begin
        failures++;
        $display("FAIL reset_prefill cycle=%0d got=%b required=0001", i, a_req_grant);
      end
      push_a(0);
      @(posedge clk); #1;
    end
    a_req_hdr[HW +: HW] = mk_hdr(1, 1'b1, 8'h56);
    a_req_valid = 4'b0010;
    @(negedge clk);
    checks++;
    if (a_req_grant !== 4'b0000) begin
      failures++;
      $display("FAIL reset_enter_drain got=%b required=0000", a_req_grant);
    end
    @(posedge clk); #3;
    rst_n = 1'b0;
    a_q.delete();
    a_tid = '0;
    #1;
    checks++;
    if ({a_out_valid, a_out_hdr, a_out_tid, a_out_src, a_outstanding, a_err} !== '0) begin
      failures++;
      $display("FAIL reset_async got valid=%b tid=%0h src=%0d outst=%0d err=%b required all 0",
               a_out_valid, a_out_tid, a_out_src, a_outstanding, a_err);
    end
    for (int s = 0; s < 4; s++) a_req_hdr[s*HW +: HW] = mk_hdr(s, 1'b0, 8'(8'h60 + s));
    a_req_valid = 4'hF;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (a_req_grant !== 4'b0001) begin
      failures++;
      $display("FAIL reset_first_grant got=%b required=0001", a_req_grant);
    end
    push_a(0);
    @(posedge clk); #1 a_req_valid = '0;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_almfull();
    test_limit();
    test_tid_wrap();
    test_fence_drain();
    test_underflow_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (a_q.size() != 0 || b_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got a=%0d b=%0d required 0/0", a_q.size(), b_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
